// File: rtl/core_pkg.sv
// Shared decode constants and types for the decode/execute boundary.
package core_pkg;

  // Immediate format selector driven to the extension unit.
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_t;

  // Write-back result source selector.
  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  // Base-ISA opcodes recognised by the main decoder.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Main control bundle carried through the ID/EX register.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] result_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{default: '0};

endpackage : core_pkg

// File: rtl/id_main_decoder.sv
// Combinational main decoder: opcode -> immediate type, controls, illegal flag.
module id_main_decoder
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  output imm_src_t   imm_src,
  output ctrl_t      ctrl,
  output logic       illegal
);

  // Decode the opcode into the immediate format and main controls.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    imm_src = IMM_I;
    ctrl    = CTRL_NONE;
    illegal = 1'b0;
    unique case (opcode)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RESULT_MEM;
      end
      OP_ALUI: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RESULT_ALU;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RESULT_PC4;
      end
      OP_STORE: begin
        imm_src        = IMM_S;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        imm_src     = IMM_B;
        ctrl.branch = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm_src        = IMM_U;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_JAL: begin
        imm_src         = IMM_J;
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RESULT_PC4;
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule : id_main_decoder

// File: rtl/id_ex_ctrl.sv
// Decode-to-execute controller: opcode decode, valid/ready handshake,
// ID/EX pipeline register and RUN/TRAP sequencing for illegal opcodes.
module id_ex_ctrl
  import core_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] InstrD,
  input  logic            ValidD,
  output logic            ReadyD,
  output logic [2:0]      ImmSrcD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            TrapAck,
  output logic            ValidE,
  output logic [XLEN-1:0] InstrE,
  output logic [XLEN-1:0] ImmExtE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic            IllegalE,
  output logic            TrapPending
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_TRAP = 1'b1;

  logic [0:0] state, state_nxt;

  imm_src_t dec_imm_src;
  ctrl_t    dec_ctrl;
  logic     dec_illegal;

  ctrl_t    ctrl_e;
  logic     hold;
  logic     accept;
  logic     trap_on_accept;

  id_main_decoder u_dec (
    .opcode  (InstrD[6:0]),
    .imm_src (dec_imm_src),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign ImmSrcD = dec_imm_src;

  // Handshake: execute holding a live instruction or a redirect blocks intake.
  assign hold           = ValidE && StallE && !FlushE;
  assign ReadyD         = (state == ST_RUN) && !(ValidE && StallE) && !FlushE;
  assign accept         = ValidD && ReadyD;
  assign trap_on_accept = accept && dec_illegal && (TRAP_ON_ILLEGAL != 0);

  // RUN/TRAP next state: an accepted illegal traps, ack or redirect resumes.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (trap_on_accept)     state_nxt = ST_TRAP;
      ST_TRAP: if (TrapAck || FlushE)  state_nxt = ST_RUN;
      default:                         state_nxt = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // ID/EX register: flush > hold > accept > bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidE    <= 1'b0;
      IllegalE  <= 1'b0;
      InstrE    <= '0;
      ImmExtE   <= '0;
      ctrl_e    <= CTRL_NONE;
    end else if (FlushE) begin
      ValidE    <= 1'b0;
      IllegalE  <= 1'b0;
    end else if (hold) begin
      ValidE    <= ValidE;
    end else if (accept) begin
      InstrE    <= InstrD;
      ImmExtE   <= ImmExtD;
      // The decoder already zeroes controls for an illegal opcode.
      ctrl_e    <= dec_ctrl;
      IllegalE  <= dec_illegal;
      // Without trapping, an illegal opcode travels as a flagged bubble.
      ValidE    <= !dec_illegal || (TRAP_ON_ILLEGAL != 0);
    end else begin
      ValidE    <= 1'b0;
      IllegalE  <= 1'b0;
    end
  end

  assign RegWriteE   = ctrl_e.reg_write;
  assign MemWriteE   = ctrl_e.mem_write;
  assign BranchE     = ctrl_e.branch;
  assign JumpE       = ctrl_e.jump;
  assign ALUSrcE     = ctrl_e.alu_src;
  assign ResultSrcE  = ctrl_e.result_src;
  assign TrapPending = (state == ST_TRAP);

endmodule : id_ex_ctrl

// File: tb/tb_id_ex_ctrl.sv
// Self-checking bench for id_ex_ctrl: table-driven decode stream plus
// directed stall, flush, trap and reset sequences.
module tb_id_ex_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] InstrD;
  logic        ValidD;
  logic        ReadyD;
  logic [2:0]  ImmSrcD;
  logic [31:0] ImmExtD;
  logic        StallE, FlushE, TrapAck;
  logic        ValidE;
  logic [31:0] InstrE, ImmExtE;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic        IllegalE, TrapPending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_ctrl #(.XLEN(32), .TRAP_ON_ILLEGAL(1)) dut (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .ValidD(ValidD), .ReadyD(ReadyD),
    .ImmSrcD(ImmSrcD), .ImmExtD(ImmExtD), .StallE(StallE), .FlushE(FlushE),
    .TrapAck(TrapAck), .ValidE(ValidE), .InstrE(InstrE), .ImmExtE(ImmExtE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .IllegalE(IllegalE),
    .TrapPending(TrapPending)
  );

  // Reference immediate extension unit answering the DUT's ImmSrcD request.
  always_comb begin
    case (ImmSrcD)
      3'b000:  ImmExtD = {{20{InstrD[31]}}, InstrD[31:20]};
      3'b001:  ImmExtD = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      3'b010:  ImmExtD = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      3'b011:  ImmExtD = {InstrD[31:12], 12'b0};
      3'b100:  ImmExtD = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: ImmExtD = 32'h0;
    endcase
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic [31:0] imm_ext;
    logic [6:0]  ctrl; // {reg_write, mem_write, branch, jump, alu_src, result_src}
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_e();
    return {RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ResultSrcE};
  endfunction

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ValidD = 1'b0; InstrD = 32'h0; StallE = 1'b0; FlushE = 1'b0; TrapAck = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"lw",    32'h00412083, 3'b000, 32'h00000004, 7'b10001_01};
    vecs[1] = '{"sw",    32'h00112423, 3'b001, 32'h00000008, 7'b01001_00};
    vecs[2] = '{"addi",  32'hFFF00093, 3'b000, 32'hFFFFFFFF, 7'b10001_00};
    vecs[3] = '{"jalr",  32'h00008067, 3'b000, 32'h00000000, 7'b10011_10};
    vecs[4] = '{"beq",   32'h00208863, 3'b010, 32'h00000010, 7'b00100_00};
    vecs[5] = '{"lui",   32'h123452B7, 3'b011, 32'h12345000, 7'b10001_00};
    vecs[6] = '{"auipc", 32'h00001097, 3'b011, 32'h00001000, 7'b10001_00};
    vecs[7] = '{"jal",   32'hFFDFF0EF, 3'b100, 32'hFFFFFFFC, 7'b10010_10};
    vecs[8] = '{"add",   32'h002081B3, 3'b000, 32'h00000002, 7'b10000_00};

    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_validE",   32'(ValidE), 32'd0);
    check("rst_instrE",   InstrE, 32'h0);
    check("rst_trap",     32'(TrapPending), 32'd0);
    check("rst_ctrl",     32'(ctrl_e()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_readyD",   32'(ReadyD), 32'd1);

    // Back-to-back stream through every legal opcode class.
    for (int i = 0; i < 9; i++) begin
      InstrD = vecs[i].instr;
      ValidD = 1'b1;
      #1;
      check({vecs[i].name, "_immsrc"}, 32'(ImmSrcD), 32'(vecs[i].imm_src));
      check({vecs[i].name, "_ready"},  32'(ReadyD), 32'd1);
      tick();
      check({vecs[i].name, "_validE"}, 32'(ValidE), 32'd1);
      check({vecs[i].name, "_instrE"}, InstrE, vecs[i].instr);
      check({vecs[i].name, "_immE"},   ImmExtE, vecs[i].imm_ext);
      check({vecs[i].name, "_ctrl"},   32'(ctrl_e()), 32'(vecs[i].ctrl));
      check({vecs[i].name, "_illE"},   32'(IllegalE), 32'd0);
    end
    ValidD = 1'b0;
    tick();
    check("bubble_validE", 32'(ValidE), 32'd0);

    // Stall: lw in E, sw waits three cycles then enters as stall drops.
    InstrD = 32'h00412083; ValidD = 1'b1;
    tick();
    InstrD = 32'h00112423; StallE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_ready", 32'(ReadyD), 32'd0);
      tick();
      check("stall_instrE", InstrE, 32'h00412083);
      check("stall_immE",   ImmExtE, 32'h00000004);
      check("stall_validE", 32'(ValidE), 32'd1);
    end
    StallE = 1'b0;
    #1;
    check("unstall_ready", 32'(ReadyD), 32'd1);
    tick();
    check("unstall_instrE", InstrE, 32'h00112423);
    check("unstall_memw",   32'(MemWriteE), 32'd1);

    // Stall and flush together: flush wins.
    StallE = 1'b1; FlushE = 1'b1; InstrD = 32'hFFF00093;
    #1;
    check("flush_ready", 32'(ReadyD), 32'd0);
    tick();
    check("flush_validE", 32'(ValidE), 32'd0);
    idle_inputs();

    // TrapAck outside TRAP has no effect.
    TrapAck = 1'b1;
    tick();
    check("ack_run_trap",  32'(TrapPending), 32'd0);
    check("ack_run_ready", 32'(ReadyD), 32'd1);
    TrapAck = 1'b0;

    // Illegal opcode enters TRAP; resumes one cycle after TrapAck.
    InstrD = 32'h0000007F; ValidD = 1'b1;
    #1;
    check("ill_immsrc", 32'(ImmSrcD), 32'd0);
    tick();
    check("ill_illE",   32'(IllegalE), 32'd1);
    check("ill_validE", 32'(ValidE), 32'd1);
    check("ill_ctrl",   32'(ctrl_e()), 32'd0);
    check("ill_trap",   32'(TrapPending), 32'd1);
    check("ill_ready",  32'(ReadyD), 32'd0);
    InstrD = 32'hFFF00093;
    tick();
    check("trap_validE", 32'(ValidE), 32'd0);
    check("trap_illE",   32'(IllegalE), 32'd0);
    check("trap_ready",  32'(ReadyD), 32'd0);
    tick();
    check("trap_hold", 32'(TrapPending), 32'd1);
    TrapAck = 1'b1;
    #1;
    check("ack_ready", 32'(ReadyD), 32'd0);
    tick();
    TrapAck = 1'b0;
    check("ack_trap",  32'(TrapPending), 32'd0);
    check("ack_ready2", 32'(ReadyD), 32'd1);
    tick();
    check("resume_instrE", InstrE, 32'hFFF00093);
    check("resume_validE", 32'(ValidE), 32'd1);

    // Illegal held by stall keeps IllegalE; flush then leaves TRAP.
    InstrD = 32'h0000007F;
    tick();
    ValidD = 1'b0; StallE = 1'b1;
    tick();
    check("ill_hold_illE",   32'(IllegalE), 32'd1);
    check("ill_hold_validE", 32'(ValidE), 32'd1);
    FlushE = 1'b1;
    tick();
    idle_inputs();
    check("flush_trap",      32'(TrapPending), 32'd0);
    check("flush_trap_illE", 32'(IllegalE), 32'd0);
    #1;
    check("flush_trap_ready", 32'(ReadyD), 32'd1);

    // Asynchronous reset in TRAP with a live illegal in E.
    InstrD = 32'h0000007F; ValidD = 1'b1;
    tick();
    ValidD = 1'b0;
    check("pre_rst_trap", 32'(TrapPending), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_validE", 32'(ValidE), 32'd0);
    check("arst_illE",   32'(IllegalE), 32'd0);
    check("arst_trap",   32'(TrapPending), 32'd0);
    check("arst_instrE", InstrE, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_ready", 32'(ReadyD), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_id_ex_ctrl
